sr_drive_sequencer: RTL and testbench
=====================================

// Module: sr_drive_sequencer
// PURPOSE
//  Upstream driver for the clocked SR flip-flop (ports S, R, Q). Converts two raw, bouncy
//  button-level requests (set_in, reset_in) into clean, mutually exclusive S/R drive pulses.
//  Synchronises, debounces and edge-detects each input, then arbitrates.
//  Checks the flip-flop's Q (fed back) against the commanded state.
//  Guarantees S=R=1 is never presented to the flip-flop.
// PARAMETERS
//  DEBOUNCE_CYCLES  4  consecutive stable synchronised samples needed to accept a level change (>=1)
//  PULSE_CYCLES     1  cycles S or R held high per command (>=1)
//  GAP_CYCLES       2  cycles S=R=0 after each pulse before the next command (>=1)
//  CNT_W            8  counter width; must hold max(DEBOUNCE_CYCLES, PULSE_CYCLES, GAP_CYCLES)
// PORTS
//  clk       in   1  single clock; all state on rising edge
//  rst_n     in   1  reset, synchronous, active-low
//  set_in    in   1  raw asynchronous set request (level, may bounce)
//  reset_in  in   1  raw asynchronous reset request (level, may bounce)
//  q_fb      in   1  Q from the downstream SR flip-flop
//  S         out  1  set drive to flip-flop (registered)
//  R         out  1  reset drive to flip-flop (registered)
//  busy      out  1  high in any state other than IDLE
//  conflict  out  1  one-cycle pulse: set and reset edges accepted in the same cycle
//  mismatch  out  1  one-cycle pulse: q_fb differs from commanded state at check point
// BEHAVIOUR
//  Reset (rst_n=0 at a rising edge): next cycle S=R=busy=conflict=mismatch=0.
//    Also: FSM=IDLE, sync/debounce regs and counters=0, pending=NONE, exp_valid=0.
//    Reset mid-pulse drops S/R immediately; no pending command survives.
//  Input path, per input: 2-flop synchroniser.
//    Debounce counter increments while sync output != debounced level.
//    Counter clears when they match.
//    Debounced level flips when counter==DEBOUNCE_CYCLES-1 and still differing.
//    Request = debounced rising edge; one cycle wide. Falling edges are ignored.
//  Pending command: 2-bit register NONE/SET/RST, one deep.
//    A new request overwrites pending: latest intent wins.
//    Set and reset requests in the same cycle: conflict=1 for that cycle, pending<=NONE.
//  FSM states and transitions:
//    IDLE:
//      pending SET -> DRIVE_S; pending RST -> DRIVE_R.
//      Pending is cleared on the transition edge.
//    DRIVE_S:
//      S=1, R=0 for exactly PULSE_CYCLES cycles, then GAP.
//      exp_q<=1, exp_valid<=1 on exit.
//    DRIVE_R:
//      R=1, S=0 for exactly PULSE_CYCLES cycles, then GAP.
//      exp_q<=0, exp_valid<=1 on exit.
//    GAP:
//      S=R=0 for GAP_CYCLES cycles, then IDLE.
//      First GAP cycle: mismatch=(q_fb!=exp_q).
//  Requests arriving in DRIVE/GAP are latched into pending and served after returning to IDLE.
//  Latency: raw input rising and held stable -> S (or R) rises on edge 2+DEBOUNCE_CYCLES+2
//    after the first sampling edge (8 edges at defaults).
//  A request arriving during a pulse of the same command is still served, as a second pulse.
//  S&R==0 in every cycle, including across reset.
// STRUCTURE
//  Include file sr_drive_defs.vh:
//    FSM state encodings IDLE/DRIVE_S/DRIVE_R/GAP.
//    Pending codes NONE/SET/RST.
//  Sub-module sr_input_debouncer (synchroniser + debounce counter + rising-edge detect),
//    instantiated twice. Ports: clk, rst_n, raw_in, level_out, rise_out.
//  Top holds pending register, FSM, pulse/gap counter, exp_q/exp_valid, mismatch compare.
// TESTING (defaults; bench instantiates the SR flip-flop on S/R/Q)
//  1. Reset, then hold set_in=1:
//     S=1 for 1 cycle on edge 8, then Q=1, busy low after GAP, mismatch=0.
//  2. set_in toggled every cycle for 3 cycles, then 0:
//     No S pulse.
//     set_in held 1 for exactly 4 samples: one S pulse.
//  3. set_in and reset_in rise on the same edge and are held:
//     conflict=1 for one cycle, S and R stay 0, busy stays 0.
//  4. reset_in rises during an S pulse:
//     S pulse completes, 2 gap cycles follow, then R=1 for 1 cycle, Q=0.
//     S&R never 1.
//  5. Bench forces q_fb=0 after a set command:
//     mismatch=1 exactly in the first GAP cycle.
//  6. rst_n=0 while S=1:
//     S=0 next cycle, pending lost.
//     After release no pulse until a fresh debounced edge.

Source files
------------

// File: rtl/sr_drive_sequencer_pkg.sv
// sr_drive_sequencer_pkg: FSM state and pending-command encodings
// shared by the SR drive sequencer and its bench.
package sr_drive_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DRIVE_S = 2'd1,
    ST_DRIVE_R = 2'd2,
    ST_GAP     = 2'd3
  } fsm_e;

  typedef enum logic [1:0] {
    PEND_NONE = 2'd0,
    PEND_SET  = 2'd1,
    PEND_RST  = 2'd2
  } pend_e;

endpackage

// File: rtl/sr_input_debouncer.sv
// sr_input_debouncer: 2-flop sync, debounce counter, rising-edge pulse.
// Ports: clk, rst_n (sync, active-low), raw_in, level_out, rise_out.
module sr_input_debouncer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_in,
  output logic level_out,
  output logic rise_out
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             level_q;
  logic             level_d1;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      level_q  <= 1'b0;
      level_d1 <= 1'b0;
      cnt      <= '0;
    end else begin
      sync1    <= raw_in;
      sync2    <= sync1;
      level_d1 <= level_q;
      if (sync2 == level_q) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        cnt     <= '0;
        level_q <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign level_out = level_q;
  assign rise_out  = level_q & ~level_d1;

endmodule

// File: rtl/sr_drive_sequencer.sv
// sr_drive_sequencer: turns bouncy set/reset buttons into clean,
// exclusive S/R pulses for an SR flip-flop and checks its Q.
// Ports: clk, rst_n, set_in, reset_in, q_fb -> S, R, busy,
//        conflict, mismatch.
module sr_drive_sequencer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_CYCLES    = 1,
  parameter int GAP_CYCLES      = 2,
  parameter int CNT_W           = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic set_in,
  input  logic reset_in,
  input  logic q_fb,
  output logic S,
  output logic R,
  output logic busy,
  output logic conflict,
  output logic mismatch
);

  import sr_drive_sequencer_pkg::*;

  localparam logic [CNT_W-1:0] PULSE_LAST =
    CNT_W'(PULSE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST =
    CNT_W'(GAP_CYCLES - 1);

  logic             set_lvl;
  logic             rst_lvl;
  logic             set_rise;
  logic             rst_rise;
  logic             unused_lvl;
  pend_e            pend;
  fsm_e             state;
  fsm_e             state_nxt;
  logic [CNT_W-1:0] cnt;
  logic             exp_q;
  logic             exp_valid;
  logic             s_d;
  logic             r_d;
  logic             gap_first;

  sr_input_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_set_db (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw_in    (set_in),
    .level_out (set_lvl),
    .rise_out  (set_rise)
  );

  sr_input_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_rst_db (
    .clk       (clk),
    .rst_n     (rst_n),
    .raw_in    (reset_in),
    .level_out (rst_lvl),
    .rise_out  (rst_rise)
  );

  // Debounced levels are kept on the sub-module for probing only.
  assign unused_lvl = set_lvl ^ rst_lvl;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state || state == ST_IDLE)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (pend == PEND_SET)
          state_nxt = ST_DRIVE_S;
        else if (pend == PEND_RST)
          state_nxt = ST_DRIVE_R;
      end
      ST_DRIVE_S, ST_DRIVE_R: begin
        if (cnt == PULSE_LAST)
          state_nxt = ST_GAP;
      end
      ST_GAP: begin
        if (cnt == GAP_LAST)
          state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    s_d       = 1'b0;
    r_d       = 1'b0;
    gap_first = 1'b0;
    unique case (1'b1)
      (state_nxt == ST_DRIVE_S): s_d = 1'b1;
      (state_nxt == ST_DRIVE_R): r_d = 1'b1;
      default: ;
    endcase
    if (state == ST_GAP && cnt == '0)
      gap_first = 1'b1;
  end

  assign busy     = (state != ST_IDLE);
  assign conflict = set_rise & rst_rise;
  assign mismatch = gap_first & exp_valid
                  & (q_fb != exp_q);

  // S/R come from flops loaded with the next-state decode,
  // so both can never be high and reset clears them at once.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      S <= 1'b0;
      R <= 1'b0;
    end else begin
      S <= s_d;
      R <= r_d;
    end
  end

  // A fresh request beats the clear-on-accept of the old one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend      <= PEND_NONE;
      exp_q     <= 1'b0;
      exp_valid <= 1'b0;
    end else begin
      if (set_rise & rst_rise)
        pend <= PEND_NONE;
      else if (set_rise)
        pend <= PEND_SET;
      else if (rst_rise)
        pend <= PEND_RST;
      else if (state == ST_IDLE && state_nxt != ST_IDLE)
        pend <= PEND_NONE;
      if (state == ST_DRIVE_S && state_nxt == ST_GAP) begin
        exp_q     <= 1'b1;
        exp_valid <= 1'b1;
      end
      if (state == ST_DRIVE_R && state_nxt == ST_GAP) begin
        exp_q     <= 1'b0;
        exp_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sr_drive_sequencer.sv
// tb_sr_drive_sequencer: bench for sr_drive_sequencer with an SR
// flip-flop on S/R, a timeline reference model and directed cases.
module tb_sr_drive_sequencer;

  localparam int DB = 4;
  localparam int P  = 1;
  localparam int G  = 2;

  logic clk      = 1'b0;
  logic rst_n    = 1'b0;
  logic set_in   = 1'b0;
  logic reset_in = 1'b0;
  logic q_fb;
  logic s, r, busy, conflict, mismatch;
  logic ff_q    = 1'b0;
  logic frc_en  = 1'b0;
  logic frc_val = 1'b0;

  int n_chk  = 0;
  int n_fail = 0;

  assign q_fb = frc_en ? frc_val : ff_q;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (s) ff_q <= 1'b1;
    else if (r) ff_q <= 1'b0;
  end

  sr_drive_sequencer #(
    .DEBOUNCE_CYCLES (DB),
    .PULSE_CYCLES    (P),
    .GAP_CYCLES      (G),
    .CNT_W           (8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .set_in   (set_in),
    .reset_in (reset_in),
    .q_fb     (q_fb),
    .S        (s),
    .R        (r),
    .busy     (busy),
    .conflict (conflict),
    .mismatch (mismatch)
  );

  // Reference model: timeline of raw samples, a sliding window
  // per input, and a command schedule kept as start/free times.
  int          t_edge  = 0;
  logic [1:0]  dq_s    = '0;
  logic [1:0]  dq_r    = '0;
  logic [DB-1:0] hs    = '0;
  logic [DB-1:0] hr    = '0;
  logic        lv_s    = 1'b0;
  logic        lv_r    = 1'b0;
  logic        rs_m    = 1'b0;
  logic        rr_m    = 1'b0;
  int          pend    = 0;
  int          c_kind  = 0;
  int          c_start = -100;
  int          c_free  = 0;
  logic        e_s, e_r, e_busy, e_gf, e_conf;

  task automatic model_step(input logic rst,
                            input logic si,
                            input logic ri);
    logic ss, sr_;
    bit   started;
    int   t;
    t = t_edge;
    if (!rst) begin
      dq_s = '0; dq_r = '0; hs = '0; hr = '0;
      lv_s = 0; lv_r = 0; rs_m = 0; rr_m = 0;
      pend = 0; c_kind = 0; c_start = -100; c_free = 0;
    end else begin
      started = 0;
      if (t >= c_free && pend != 0) begin
        c_kind  = pend;
        c_start = t;
        c_free  = t + P + G + 1;
        started = 1;
      end
      if (rs_m && rr_m) pend = 0;
      else if (rs_m) pend = 1;
      else if (rr_m) pend = 2;
      else if (started) pend = 0;
      ss  = dq_s[1];
      sr_ = dq_r[1];
      dq_s = {dq_s[0], si};
      dq_r = {dq_r[0], ri};
      hs = {hs[DB-2:0], ss};
      hr = {hr[DB-2:0], sr_};
      rs_m = 1'b0;
      rr_m = 1'b0;
      if (hs == {DB{~lv_s}}) begin
        lv_s = ~lv_s;
        rs_m = lv_s;
      end
      if (hr == {DB{~lv_r}}) begin
        lv_r = ~lv_r;
        rr_m = lv_r;
      end
    end
    e_s    = (c_kind == 1) && t >= c_start && t < c_start + P;
    e_r    = (c_kind == 2) && t >= c_start && t < c_start + P;
    e_busy = t >= c_start && t < c_start + P + G;
    e_gf   = (t == c_start + P);
    e_conf = rs_m && rr_m;
    t_edge = t_edge + 1;
  endtask

  task automatic check(input string name,
                       input logic act,
                       input logic exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name,
                           input int act,
                           input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  task automatic tick();
    logic mm_exp;
    @(posedge clk);
    model_step(rst_n, set_in, reset_in);
    #1;
    mm_exp = e_gf && (q_fb != (c_kind == 1));
    check("S", s, e_s);
    check("R", r, e_r);
    check("busy", busy, e_busy);
    check("conflict", conflict, e_conf);
    check("mismatch", mismatch, mm_exp);
    check("s_and_r", s & r, 1'b0);
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    set_in   = 1'b0;
    reset_in = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic si;
    logic ri;
    logic s;
    logic r;
    logic busy;
    logic q;
  } vec_t;

  vec_t tbl [12];

  initial begin
    int ns, nr, nc, nb, se, re, ce;
    int hold_s, hold_r;

    tbl = '{
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0},
      '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0},
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1},
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1},
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1},
      '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1}
    };

    // Case 1: held set, S on edge 8, then Q=1 and idle.
    do_reset();
    check("rst_S", s, 1'b0);
    check("rst_busy", busy, 1'b0);
    for (int i = 0; i < 12; i++) begin
      set_in   = tbl[i].si;
      reset_in = tbl[i].ri;
      tick();
      check("tbl_S", s, tbl[i].s);
      check("tbl_R", r, tbl[i].r);
      check("tbl_busy", busy, tbl[i].busy);
      check("tbl_Q", ff_q, tbl[i].q);
    end

    // Case 2: 3-cycle toggle is rejected, 4 samples accepted.
    do_reset();
    ns = 0;
    for (int e = 1; e <= 14; e++) begin
      set_in = (e == 1 || e == 3);
      tick();
      ns += int'(s);
    end
    check_int("toggle_no_pulse", ns, 0);
    ns = 0;
    for (int e = 1; e <= 14; e++) begin
      set_in = (e <= 4);
      tick();
      ns += int'(s);
    end
    check_int("four_samples_pulse", ns, 1);

    // Case 3: simultaneous set and reset.
    do_reset();
    ns = 0; nr = 0; nc = 0; nb = 0; ce = -1;
    for (int e = 1; e <= 14; e++) begin
      set_in   = 1'b1;
      reset_in = 1'b1;
      tick();
      ns += int'(s);
      nr += int'(r);
      nb += int'(busy);
      if (conflict) begin
        nc++;
        ce = e;
      end
    end
    check_int("conflict_count", nc, 1);
    check_int("conflict_edge", ce, 6);
    check_int("conflict_no_S", ns, 0);
    check_int("conflict_no_R", nr, 0);
    check_int("conflict_no_busy", nb, 0);

    // Case 4: reset request lands during the S pulse.
    do_reset();
    ns = 0; nr = 0; se = -1; re = -1;
    for (int e = 1; e <= 18; e++) begin
      set_in   = 1'b1;
      reset_in = (e >= 3);
      tick();
      if (s) begin ns++; se = e; end
      if (r) begin nr++; re = e; end
    end
    check_int("seq_S_edge", se, 8);
    check_int("seq_R_edge", re, 12);
    check_int("seq_S_count", ns, 1);
    check_int("seq_R_count", nr, 1);
    check("seq_Q_low", ff_q, 1'b0);

    // Case 5: forced Q=0 after set gives one mismatch pulse.
    frc_en  = 1'b1;
    frc_val = 1'b0;
    do_reset();
    for (int e = 1; e <= 14; e++) begin
      set_in   = 1'b1;
      reset_in = 1'b0;
      tick();
      check("forced_mismatch", mismatch, e == 9);
    end
    frc_en = 1'b0;

    // Case 6: reset while S=1 kills the pulse and pending RST.
    do_reset();
    for (int e = 1; e <= 8; e++) begin
      set_in   = 1'b1;
      reset_in = (e >= 3);
      tick();
    end
    check("pre_rst_S", s, 1'b1);
    rst_n    = 1'b0;
    set_in   = 1'b0;
    reset_in = 1'b0;
    tick();
    check("rst_drops_S", s, 1'b0);
    rst_n = 1'b1;
    ns = 0; nr = 0;
    for (int e = 1; e <= 16; e++) begin
      tick();
      ns += int'(s);
      nr += int'(r);
    end
    check_int("post_rst_no_S", ns, 0);
    check_int("post_rst_no_R", nr, 0);
    se = -1;
    for (int e = 1; e <= 12; e++) begin
      set_in = 1'b1;
      tick();
      if (s) se = e;
    end
    check_int("fresh_edge_S", se, 8);

    // Random bouncy traffic against the model.
    do_reset();
    hold_s = 0;
    hold_r = 0;
    for (int k = 0; k < 4000; k++) begin
      if (hold_s == 0) begin
        set_in = 1'($urandom_range(0, 1));
        hold_s = ($urandom_range(0, 1) != 0)
               ? int'($urandom_range(1, 3))
               : int'($urandom_range(4, 14));
      end else begin
        hold_s--;
      end
      if (hold_r == 0) begin
        reset_in = 1'($urandom_range(0, 1));
        hold_r = ($urandom_range(0, 1) != 0)
               ? int'($urandom_range(1, 3))
               : int'($urandom_range(4, 14));
      end else begin
        hold_r--;
      end
      if ($urandom_range(0, 49) == 0) begin
        frc_en  = 1'($urandom_range(0, 1));
        frc_val = 1'($urandom_range(0, 1));
      end
      rst_n = ($urandom_range(0, 599) != 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
